// File: rtl/dual_mem_arbiter_if.sv
// ============================================================================
// Module     : dual_mem_arbiter_if
// Description: Bundle of the cache-request and RAM signals that connect two
//              cores' icache/dcache pairs and the RAM model to the memory
//              arbiter.
//              Per-core fields are packed [core][bit] arrays.
//              master : caches + RAM model side
//                       (drives requests, ramload, ramstate)
//              slave  : arbiter side
//                       (drives waits, loads, RAM strobes, bus_err)
// Revision   : 1.0 - initial release
// ============================================================================
`default_nettype none

interface dual_mem_arbiter_if #(
    parameter int WORD_W     = 32,
    parameter int RAMSTATE_W = 2
);
    // cache request side
    logic [1:0]              iREN;
    logic [1:0][WORD_W-1:0]  iaddr;
    logic [1:0]              dREN;
    logic [1:0]              dWEN;
    logic [1:0][WORD_W-1:0]  daddr;
    logic [1:0][WORD_W-1:0]  dstore;
    logic [1:0]              iwait;
    logic [1:0]              dwait;
    logic [1:0][WORD_W-1:0]  iload;
    logic [1:0][WORD_W-1:0]  dload;
    // RAM side
    logic                    ramREN;
    logic                    ramWEN;
    logic [WORD_W-1:0]       ramaddr;
    logic [WORD_W-1:0]       ramstore;
    logic [WORD_W-1:0]       ramload;
    logic [RAMSTATE_W-1:0]   ramstate;
    // status
    logic                    bus_err;

    modport master (
        output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        input  iwait, dwait, iload, dload, ramREN, ramWEN, ramaddr, ramstore,
               bus_err
    );

    modport slave (
        input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        output iwait, dwait, iload, dload, ramREN, ramWEN, ramaddr, ramstore,
               bus_err
    );
endinterface

`default_nettype wire

// File: rtl/dual_mem_arbiter.sv
// ============================================================================
// Module     : dual_mem_arbiter
// Description: Memory-side responder for two cores' icache/dcache pairs.
//              Arbitrates the single RAM port.
//              Data requests beat instruction requests.
//              Round-robin between the cores within a class.
//              A grant is held across multi-word transfers for up to BURST
//              RAM ACCESS completions.
// Ports      : CLK   - clock, rising edge
//              nRST  - asynchronous active-low reset
//              ccif  - dual_mem_arbiter_if.slave:
//                      cache requests in, waits/loads out;
//                      RAM strobes/address/data out, ramload/ramstate in;
//                      bus_err out (sticky RAM error flag)
// Revision   : 1.0 - initial release
// ============================================================================
`default_nettype none

module dual_mem_arbiter #(
    parameter int WORD_W     = 32,
    parameter int BURST      = 4,
    parameter int RAMSTATE_W = 2
) (
    input  wire logic           CLK,
    input  wire logic           nRST,
    dual_mem_arbiter_if.slave   ccif
);

    localparam logic [RAMSTATE_W-1:0] c_RS_ACCESS  = RAMSTATE_W'(2);
    localparam logic [RAMSTATE_W-1:0] c_RS_ERROR   = RAMSTATE_W'(3);
    localparam logic [2:0]            c_BURST_LAST = 3'(BURST - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DGRANT = 2'd1,
        IGRANT = 2'd2
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;
    logic       r_gcore;
    logic       w_gcore_nxt;
    logic [2:0] r_burst_cnt;
    logic [2:0] w_burst_cnt_nxt;
    logic       r_rr_ptr;
    logic       w_rr_ptr_nxt;
    logic       r_err;
    logic       w_err_nxt;

    logic [1:0] w_dreq;
    logic [1:0] w_ireq;
    logic       w_granted_req;
    logic       w_access;

    logic [1:0]              w_iwait;
    logic [1:0]              w_dwait;
    logic [1:0][WORD_W-1:0]  w_iload;
    logic [1:0][WORD_W-1:0]  w_dload;
    logic                    w_ramREN;
    logic                    w_ramWEN;
    logic [WORD_W-1:0]       w_ramaddr;
    logic [WORD_W-1:0]       w_ramstore;

    assign w_dreq   = ccif.dREN | ccif.dWEN;
    assign w_ireq   = ccif.iREN;
    assign w_access = (ccif.ramstate == c_RS_ACCESS);

    // Whether the core holding the grant still asserts its request.
    always_comb begin
        w_granted_req = 1'b0;
        case (r_state)
            DGRANT:  w_granted_req = w_dreq[r_gcore];
            IGRANT:  w_granted_req = w_ireq[r_gcore];
            default: w_granted_req = 1'b0;
        endcase
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state     <= IDLE;
            r_gcore     <= 1'b0;
            r_burst_cnt <= 3'd0;
            r_rr_ptr    <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_gcore     <= w_gcore_nxt;
            r_burst_cnt <= w_burst_cnt_nxt;
            r_rr_ptr    <= w_rr_ptr_nxt;
            r_err       <= w_err_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt     = r_state;
        w_gcore_nxt     = r_gcore;
        w_burst_cnt_nxt = r_burst_cnt;
        w_rr_ptr_nxt    = r_rr_ptr;
        w_err_nxt       = r_err;

        case (r_state)
            IDLE: begin
                // rr_ptr core wins its class when it requests, else the other
                if (|w_dreq) begin
                    w_state_nxt     = DGRANT;
                    w_gcore_nxt     = w_dreq[r_rr_ptr] ? r_rr_ptr : ~r_rr_ptr;
                    w_burst_cnt_nxt = 3'd0;
                end else if (|w_ireq) begin
                    w_state_nxt     = IGRANT;
                    w_gcore_nxt     = w_ireq[r_rr_ptr] ? r_rr_ptr : ~r_rr_ptr;
                    w_burst_cnt_nxt = 3'd0;
                end
            end

            DGRANT, IGRANT: begin
                if (ccif.ramstate == c_RS_ERROR) begin
                    w_err_nxt = 1'b1;
                end
                // Drop the grant when the request goes away or the burst
                // budget is spent, so a waiting core gets its turn.
                if (!w_granted_req ||
                    (w_access && (r_burst_cnt == c_BURST_LAST))) begin
                    w_state_nxt  = IDLE;
                    w_rr_ptr_nxt = ~r_gcore;
                end else if (w_access) begin
                    w_burst_cnt_nxt = r_burst_cnt + 3'd1;
                end
            end

            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs: purely from the registered grant and live inputs, so an
    // asynchronous reset drops the RAM strobes in the same instant.
    // ------------------------------------------------------------------
    always_comb begin
        w_iwait    = 2'b11;
        w_dwait    = 2'b11;
        w_iload    = '0;
        w_dload    = '0;
        w_ramREN   = 1'b0;
        w_ramWEN   = 1'b0;
        w_ramaddr  = '0;
        w_ramstore = '0;

        case (r_state)
            DGRANT: begin
                w_ramaddr  = ccif.daddr[r_gcore];
                w_ramstore = ccif.dstore[r_gcore];
                // a write wins when both strobes are requested
                w_ramWEN   = ccif.dWEN[r_gcore];
                w_ramREN   = ccif.dREN[r_gcore] & ~ccif.dWEN[r_gcore];
                if (w_access) begin
                    w_dwait[r_gcore] = 1'b0;
                    w_dload[r_gcore] = ccif.ramload;
                end
            end

            IGRANT: begin
                w_ramaddr = ccif.iaddr[r_gcore];
                w_ramREN  = ccif.iREN[r_gcore];
                if (w_access) begin
                    w_iwait[r_gcore] = 1'b0;
                    w_iload[r_gcore] = ccif.ramload;
                end
            end

            default: begin
            end
        endcase
    end

    assign ccif.iwait    = w_iwait;
    assign ccif.dwait    = w_dwait;
    assign ccif.iload    = w_iload;
    assign ccif.dload    = w_dload;
    assign ccif.ramREN   = w_ramREN;
    assign ccif.ramWEN   = w_ramWEN;
    assign ccif.ramaddr  = w_ramaddr;
    assign ccif.ramstore = w_ramstore;
    assign ccif.bus_err  = r_err;

endmodule

`default_nettype wire

// File: doc/dual_mem_arbiter.md
Name: dual_mem_arbiter

Overview:
- Memory-side responder for the cache request protocol. Services icache/dcache requests from two cores (iREN/iaddr; dREN/dWEN/daddr/dstore) and answers with the per-port wait/load signals the caches poll.
- Arbitrates the single RAM port. Holds a grant across multi-word block transfers (writeback and fill) and round-robins between cores.
- Sits between both cores' cache pairs and the RAM model, in the slot the caches reach through their ccif connection.

Parameters:
- WORD_W, 32, data and address width.
- BURST, 4, max RAM ACCESS completions per grant before forced re-arbitration (covers WB1, WB2, UPDATE1, UPDATE2).
- RAMSTATE_W, 2, ramstate encoding: FREE=00, BUSY=01, ACCESS=10, ERROR=11.

Ports:
- CLK  in  1  clock, rising edge.
- nRST  in  1  reset, asynchronous, active-low.
- iREN  in  2  instruction read request, per core.
- iaddr  in  2xWORD_W  instruction address, per core.
- dREN  in  2  data read request, per core.
- dWEN  in  2  data write request, per core.
- daddr  in  2xWORD_W  data address, per core.
- dstore  in  2xWORD_W  data write value, per core.
- iwait  out  2  instruction stall, per core.
- dwait  out  2  data stall, per core.
- iload  out  2xWORD_W  instruction read data, per core.
- dload  out  2xWORD_W  data read data, per core.
- ramREN  out  1  RAM read strobe.
- ramWEN  out  1  RAM write strobe.
- ramaddr  out  WORD_W  RAM address.
- ramstore  out  WORD_W  RAM write data.
- ramload  in  WORD_W  RAM read data.
- ramstate  in  2  RAM status.
- bus_err  out  1  sticky error flag.

Behaviour:
- Registers: state {IDLE, DGRANT, IGRANT}, gcore (1b), burst_cnt (3b), rr_ptr (1b), err (1b).
- Reset values: state=IDLE, gcore=0, burst_cnt=0, rr_ptr=0, err=0.
- Output reset values: iwait=11, dwait=11, iload=dload=0, ramREN=ramWEN=0, ramaddr=ramstore=0, bus_err=0.
- Request definitions: dreq[c]=dREN[c]|dWEN[c]; ireq[c]=iREN[c].
- IDLE:
  - No RAM strobes; all waits high.
  - Any dreq pending -> DGRANT. Any ireq pending (and no dreq) -> IGRANT. Otherwise stay in IDLE.
  - Data beats instruction across both cores.
  - Within a class, core rr_ptr wins if it requests; otherwise the other core wins.
  - gcore captured and burst_cnt=0 on the transition.
  - Grant decision is registered: request seen in cycle N drives RAM from cycle N+1. Minimum latency request -> wait low is 2 cycles when RAM answers ACCESS immediately.
- DGRANT, RAM side (combinational from grant):
  - ramaddr=daddr[gcore].
  - ramWEN=dWEN[gcore]; ramREN=dREN[gcore]&~dWEN[gcore] (WEN has priority when both are set).
  - ramstore=dstore[gcore].
- DGRANT, cache side:
  - dwait[gcore]=0 only in cycles where ramstate==ACCESS. All other wait bits stay 1.
  - dload[gcore]=ramload when ramstate==ACCESS, else 0.
  - Each ACCESS cycle increments burst_cnt.
- IGRANT: same as DGRANT, using iaddr, iREN, iwait, iload; ramWEN=0.
- Release to IDLE, with rr_ptr<=~gcore, when either:
  - the granted request deasserts, or
  - burst_cnt reaches BURST-1 in an ACCESS cycle (forced re-arbitration).
- A still-pending requester re-competes in IDLE. A request change in the same cycle as release is sampled in IDLE.
- A granted core changing address between words, with the request held, keeps the grant; RAM follows the new address the same cycle.
- Only one wait bit is ever low in a cycle; never two.
- ramstate BUSY/FREE while granted: stay, waits high, strobes held.
- ramstate ERROR while granted:
  - err<=1; bus_err=err (sticky until reset).
  - Waits remain high; the grant is held so the RAM may retry.
- Async reset mid-transaction: grant and all state cleared immediately; strobes drop in the same instant.
- dload and iload for non-granted cores are 0.

Test Plan:
- Core0 dREN=1, daddr=0x100, RAM gives BUSY×2 then ACCESS with ramload=0xDEADBEEF -> ramREN=1 from cycle 1; dwait[0]=0 and dload[0]=0xDEADBEEF only in the ACCESS cycle; return to IDLE after dREN drops.
- Both cores raise dREN in the same cycle after reset (rr_ptr=0) -> core0 served first; after release rr_ptr=1 and core1 granted; dwait[1] never low during core0's ACCESS.
- Core1 iREN and core0 dWEN (daddr=0x40, dstore=0x12345678) simultaneous -> DGRANT core0 first; ramWEN=1, ramstore=0x12345678; IGRANT core1 afterward.
- Core0 holds dWEN/dREN through 5 ACCESS beats (addresses 0x80, 0x84, 0x80, 0x84, 0x88) while core1 holds dREN -> forced release after the 4th ACCESS; core1 granted next; core0 resumes later.
- ramstate=ERROR for 1 cycle during DGRANT -> bus_err=1 from the next cycle and stays 1; dwait stays high; a following ACCESS completes normally.
- nRST pulsed low during DGRANT with ramstate=BUSY -> ramREN/ramWEN=0 immediately; all waits=1; state IDLE; bus_err=0 after reset.
